trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences machine-mode trap entry between the pipeline and the CSR file. It synchronises the MEIP/MTIP/MSIP lines and gates them with the CSR-file enables. It arbitrates pending interrupts against synchronous exceptions, then flushes and drains the pipeline. Once the pipeline is empty it hands one trap (cause + EPC) to the CSR file over a request/acknowledge handshake, and the CSR file's priv-jump logic redirects fetch.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in each interrupt-line synchroniser (≥2).
- DRAIN_MAX, 64: maximum cycles spent in DRAIN before forcing the request (≥2).

Ports:
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- MEIP  in  1  external interrupt pending, level, asynchronous.
- MTIP  in  1  timer interrupt pending, level, asynchronous.
- MSIP  in  1  software interrupt pending, level, asynchronous.
- MIE_EN  in  1  mstatus.MIE from the CSR file.
- MIE_MASK  in  3  {MEIE, MTIE, MSIE} from the CSR file's mie register.
- EXC_VALID  in  1  synchronous exception raised by the pipeline this cycle.
- EXC_CAUSE  in  4  exception code (ecall = 11, ebreak = 3, ...).
- EXC_PC  in  32  PC of the faulting instruction.
- COMMIT_PC  in  32  PC of the oldest uncommitted instruction.
- PIPE_EMPTY  in  1  pipeline has no in-flight instructions.
- TRAP_ACK  in  1  CSR file has written mepc/mcause and raised PRIV_JUMP.
- PIPE_STALL  out  1  hold fetch/decode.
- PIPE_FLUSH  out  1  one-cycle kill of all in-flight instructions.
- TRAP_REQ  out  1  trap pending at the CSR file.
- TRAP_CAUSE  out  32  mcause value.
- TRAP_EPC  out  32  mepc value.
- BUSY  out  1  state ≠ IDLE.
- DRAIN_ERR  out  1  sticky: a drain timed out.

## Operation
- Each of MEIP/MTIP/MSIP passes through a SYNC_STAGES flop chain reset to 0; only the synchronised copies (sMEIP, sMTIP, sMSIP) are used.
- Interrupt x is enabled when MIE_EN & its MIE_MASK bit & its synchronised line are all 1.
- Event detection is evaluated only in IDLE. Priority:
  - EXC_VALID: TRAP_CAUSE = {28'b0, EXC_CAUSE}, TRAP_EPC = EXC_PC.
  - MEI enabled: cause 0x8000000B.
  - MSI enabled: cause 0x80000003.
  - MTI enabled: cause 0x80000007.
  - For any interrupt, TRAP_EPC = COMMIT_PC.
- Cause and EPC are latched on the IDLE→FLUSH edge and held until the next capture. Later changes to inputs do not alter them; an interrupt that drops during DRAIN is still taken.
- The losing event is not queued. Interrupts are levels and are re-evaluated on return to IDLE. Exceptions not in IDLE are ignored, because the flush discards their instruction.
- FSM states:
  - IDLE: → FLUSH on any event.
  - FLUSH: PIPE_FLUSH = 1; → DRAIN.
  - DRAIN: drain counter clears on entry and increments each cycle. → REQ when PIPE_EMPTY = 1, or when the counter reaches DRAIN_MAX−1; in the timeout case also set DRAIN_ERR.
  - REQ: TRAP_REQ = 1; → HOLD when TRAP_ACK = 1.
  - HOLD: one cycle so the cleared mstatus.MIE reaches MIE_EN; → IDLE.
- Output decode:
  - PIPE_STALL = 1 in FLUSH, DRAIN, REQ and HOLD.
  - BUSY = PIPE_STALL.
  - All outputs are registered or decoded from state registers only.
- TRAP_ACK outside REQ is ignored. DRAIN_ERR clears only on RST.

## Timing
- Reset values: state IDLE, synchronisers 0, counter 0, DRAIN_ERR 0. All outputs 0, including TRAP_CAUSE and TRAP_EPC.
- RST asserted mid-sequence returns to IDLE immediately (asynchronously) and drops all outputs; no partial trap is signalled.
- Exception sampled in IDLE at cycle N gives:
  - FLUSH at N+1 (PIPE_FLUSH, PIPE_STALL high);
  - DRAIN at N+2;
  - REQ at N+3 at the earliest, if PIPE_EMPTY = 1 at N+2.
- An interrupt line rising at cycle N is visible to IDLE detection at N+SYNC_STAGES.
- TRAP_REQ stays high for at least one cycle and until TRAP_ACK is sampled high. The leave-REQ rule (TRAP_ACK = 1 → HOLD) applies from the first REQ cycle, so an ACK in the first REQ cycle gives a one-cycle REQ.
- Sequence after ACK: HOLD one cycle, IDLE the next. The earliest next detection is in that IDLE cycle.
- Timeout: with PIPE_EMPTY held 0, REQ begins exactly DRAIN_MAX cycles after DRAIN entry.
- Simultaneous EXC_VALID and enabled MEIP in IDLE: the exception wins. If MEIP is still enabled in the IDLE after HOLD, it is taken then.

## Test plan
- Reset: hold RST with MEIP = 1 → all outputs 0, BUSY 0; release with MIE_EN = 0 → stays IDLE.
- ecall: EXC_VALID = 1, EXC_CAUSE = 11, EXC_PC = 0x4, PIPE_EMPTY = 1, TRAP_ACK on the second REQ cycle → PIPE_FLUSH pulse at N+1, TRAP_REQ N+3..N+4, TRAP_CAUSE 0x0000000B, TRAP_EPC 0x4, IDLE at N+6.
- Priority: MEIP = MTIP = MSIP = 1, MIE_EN = 1, MIE_MASK = 3'b111, COMMIT_PC = 0x100 → TRAP_CAUSE 0x8000000B, TRAP_EPC 0x100. With MEIP masked → 0x80000003. With MSIP also masked → 0x80000007.
- Simultaneous exception + MTI: exception cause is delivered first. After ACK, MIE_EN is still 1 → a second sequence starts with cause 0x80000007.
- Drain timeout: DRAIN_MAX = 64, PIPE_EMPTY held 0 → TRAP_REQ rises exactly 64 cycles after DRAIN entry, and DRAIN_ERR = 1 until RST.
- Mid-operation reset: pulse RST during REQ → TRAP_REQ and PIPE_STALL drop asynchronously. The next event restarts from FLUSH with a freshly latched cause.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry sequencer: synchronises interrupt lines, arbitrates them
// against synchronous exceptions, flushes/drains the pipeline and hands one trap to the CSR file.
module trap_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int DRAIN_MAX   = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEIP,
  input  logic        MTIP,
  input  logic        MSIP,
  input  logic        MIE_EN,
  input  logic [2:0]  MIE_MASK,
  input  logic        EXC_VALID,
  input  logic [3:0]  EXC_CAUSE,
  input  logic [31:0] EXC_PC,
  input  logic [31:0] COMMIT_PC,
  input  logic        PIPE_EMPTY,
  input  logic        TRAP_ACK,
  output logic        PIPE_STALL,
  output logic        PIPE_FLUSH,
  output logic        TRAP_REQ,
  output logic [31:0] TRAP_CAUSE,
  output logic [31:0] TRAP_EPC,
  output logic        BUSY,
  output logic        DRAIN_ERR
);

  localparam int CW = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    DRAIN = 3'd2,
    REQ   = 3'd3,
    HOLD  = 3'd4
  } stateT;

  stateT r_state;
  stateT w_nextState;

  logic [SYNC_STAGES-1:0][2:0] r_irqSync;
  logic [2:0]                  w_irqSync;
  logic [2:0]                  w_irqEn;
  logic [CW-1:0]               r_drainCnt;
  logic                        r_drainErr;
  logic [31:0]                 r_trapCause;
  logic [31:0]                 r_trapEpc;
  logic                        w_event;
  logic [31:0]                 w_cause;
  logic [31:0]                 w_epc;
  logic                        w_drainDone;

  // Bit order {MEI, MTI, MSI} matches MIE_MASK = {MEIE, MTIE, MSIE}.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_irqSync <= '0;
    end else begin
      r_irqSync <= {r_irqSync[SYNC_STAGES-2:0], {MEIP, MTIP, MSIP}};
    end
  end

  assign w_irqSync = r_irqSync[SYNC_STAGES-1];
  assign w_irqEn   = {3{MIE_EN}} & MIE_MASK & w_irqSync;

  // Exception beats interrupts; among interrupts MEI > MSI > MTI.
  always_comb begin
    w_event = 1'b1;
    w_cause = {28'b0, EXC_CAUSE};
    w_epc   = EXC_PC;
    if (EXC_VALID) begin
      w_cause = {28'b0, EXC_CAUSE};
      w_epc   = EXC_PC;
    end else if (w_irqEn[2]) begin
      w_cause = 32'h8000_000B;
      w_epc   = COMMIT_PC;
    end else if (w_irqEn[0]) begin
      w_cause = 32'h8000_0003;
      w_epc   = COMMIT_PC;
    end else if (w_irqEn[1]) begin
      w_cause = 32'h8000_0007;
      w_epc   = COMMIT_PC;
    end else begin
      w_event = 1'b0;
    end
  end

  assign w_drainDone = PIPE_EMPTY || (r_drainCnt == DRAIN_LAST);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_event) w_nextState = FLUSH;
      FLUSH:   w_nextState = DRAIN;
      DRAIN:   if (w_drainDone) w_nextState = REQ;
      REQ:     if (TRAP_ACK) w_nextState = HOLD;
      HOLD:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_drainCnt  <= '0;
      r_drainErr  <= 1'b0;
      r_trapCause <= '0;
      r_trapEpc   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_event) begin
        r_trapCause <= w_cause;
        r_trapEpc   <= w_epc;
      end
      if (r_state == DRAIN) begin
        r_drainCnt <= r_drainCnt + CW'(1);
      end else begin
        r_drainCnt <= '0;
      end
      // Timeout only counts as an error when the pipeline never reported empty.
      if (r_state == DRAIN && !PIPE_EMPTY && r_drainCnt == DRAIN_LAST) begin
        r_drainErr <= 1'b1;
      end
    end
  end

  assign PIPE_STALL = (r_state != IDLE);
  assign BUSY       = (r_state != IDLE);
  assign PIPE_FLUSH = (r_state == FLUSH);
  assign TRAP_REQ   = (r_state == REQ);
  assign TRAP_CAUSE = r_trapCause;
  assign TRAP_EPC   = r_trapEpc;
  assign DRAIN_ERR  = r_drainErr;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer with hand-computed expectations.
module tb_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEIP, MTIP, MSIP;
  logic        MIE_EN;
  logic [2:0]  MIE_MASK;
  logic        EXC_VALID;
  logic [3:0]  EXC_CAUSE;
  logic [31:0] EXC_PC;
  logic [31:0] COMMIT_PC;
  logic        PIPE_EMPTY;
  logic        TRAP_ACK;
  logic        PIPE_STALL;
  logic        PIPE_FLUSH;
  logic        TRAP_REQ;
  logic [31:0] TRAP_CAUSE;
  logic [31:0] TRAP_EPC;
  logic        BUSY;
  logic        DRAIN_ERR;

  int vectors = 0;
  int miscompares = 0;

  trap_sequencer #(.SYNC_STAGES(2), .DRAIN_MAX(64)) dut (
    .CLK(CLK), .RST(RST),
    .MEIP(MEIP), .MTIP(MTIP), .MSIP(MSIP),
    .MIE_EN(MIE_EN), .MIE_MASK(MIE_MASK),
    .EXC_VALID(EXC_VALID), .EXC_CAUSE(EXC_CAUSE), .EXC_PC(EXC_PC),
    .COMMIT_PC(COMMIT_PC), .PIPE_EMPTY(PIPE_EMPTY), .TRAP_ACK(TRAP_ACK),
    .PIPE_STALL(PIPE_STALL), .PIPE_FLUSH(PIPE_FLUSH), .TRAP_REQ(TRAP_REQ),
    .TRAP_CAUSE(TRAP_CAUSE), .TRAP_EPC(TRAP_EPC), .BUSY(BUSY), .DRAIN_ERR(DRAIN_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic excValid, input logic [3:0] excCause,
                               input logic [31:0] excPc, input logic pipeEmpty);
    EXC_VALID  = excValid;
    EXC_CAUSE  = excCause;
    EXC_PC     = excPc;
    PIPE_EMPTY = pipeEmpty;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doTrap(input string tag, input logic [31:0] expCause,
                        input logic [31:0] expEpc, input logic [2:0] nextMask);
    int n;
    n = 0;
    while (!PIPE_FLUSH && n < 8) begin
      tick();
      n++;
    end
    checkOutput({tag, "_flush"}, 32'(PIPE_FLUSH), 32'd1);
    checkOutput({tag, "_cause"}, TRAP_CAUSE, expCause);
    checkOutput({tag, "_epc"}, TRAP_EPC, expEpc);
    n = 0;
    while (!TRAP_REQ && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"}, 32'(TRAP_REQ), 32'd1);
    TRAP_ACK = 1'b1;
    tick();
    TRAP_ACK = 1'b0;
    MIE_MASK = nextMask;
    checkOutput({tag, "_holdReq"}, 32'(TRAP_REQ), 32'd0);
    checkOutput({tag, "_holdStall"}, 32'(PIPE_STALL), 32'd1);
    tick();
    checkOutput({tag, "_idleBusy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int n;
    RST = 1'b1;
    MEIP = 1'b1; MTIP = 1'b0; MSIP = 1'b0;
    MIE_EN = 1'b0; MIE_MASK = 3'b000;
    COMMIT_PC = 32'h0; TRAP_ACK = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

    // Reset with MEIP asserted: everything quiet.
    repeat (3) tick();
    checkOutput("rst_stall", 32'(PIPE_STALL), 32'd0);
    checkOutput("rst_flush", 32'(PIPE_FLUSH), 32'd0);
    checkOutput("rst_req", 32'(TRAP_REQ), 32'd0);
    checkOutput("rst_cause", TRAP_CAUSE, 32'd0);
    checkOutput("rst_epc", TRAP_EPC, 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_derr", 32'(DRAIN_ERR), 32'd0);
    RST = 1'b0;
    repeat (5) tick();
    checkOutput("rel_busy", 32'(BUSY), 32'd0);
    MEIP = 1'b0;
    tick();

    // ecall at cycle N with ACK on second REQ cycle.
    applyStimulus(1'b1, 4'd11, 32'h4, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    checkOutput("ecall_n1_flush", 32'(PIPE_FLUSH), 32'd1);
    checkOutput("ecall_n1_stall", 32'(PIPE_STALL), 32'd1);
    checkOutput("ecall_cause", TRAP_CAUSE, 32'h0000_000B);
    checkOutput("ecall_epc", TRAP_EPC, 32'h4);
    tick();
    checkOutput("ecall_n2_flush", 32'(PIPE_FLUSH), 32'd0);
    checkOutput("ecall_n2_req", 32'(TRAP_REQ), 32'd0);
    tick();
    checkOutput("ecall_n3_req", 32'(TRAP_REQ), 32'd1);
    tick();
    checkOutput("ecall_n4_req", 32'(TRAP_REQ), 32'd1);
    TRAP_ACK = 1'b1;
    tick();
    TRAP_ACK = 1'b0;
    checkOutput("ecall_n5_req", 32'(TRAP_REQ), 32'd0);
    checkOutput("ecall_n5_stall", 32'(PIPE_STALL), 32'd1);
    tick();
    checkOutput("ecall_n6_busy", 32'(BUSY), 32'd0);
    checkOutput("ecall_held_cause", TRAP_CAUSE, 32'h0000_000B);

    // Interrupt priority; lines rise at M, FLUSH expected at M+3.
    COMMIT_PC = 32'h100;
    MIE_EN = 1'b1; MIE_MASK = 3'b111;
    MEIP = 1'b1; MTIP = 1'b1; MSIP = 1'b1;
    n = 0;
    while (!PIPE_FLUSH && n < 10) begin
      tick();
      n++;
    end
    checkOutput("irq_sync_latency", 32'(n), 32'd3);
    doTrap("prio_mei", 32'h8000_000B, 32'h100, 3'b011);
    doTrap("prio_msi", 32'h8000_0003, 32'h100, 3'b010);
    doTrap("prio_mti", 32'h8000_0007, 32'h100, 3'b000);
    MEIP = 1'b0; MSIP = 1'b0;
    tick();
    checkOutput("masked_idle", 32'(BUSY), 32'd0);

    // Simultaneous exception and enabled MTI: exception first, then MTI.
    MIE_MASK = 3'b010;
    COMMIT_PC = 32'h300;
    applyStimulus(1'b1, 4'd3, 32'h200, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    doTrap("simul_exc", 32'h0000_0003, 32'h200, 3'b010);
    doTrap("simul_mti", 32'h8000_0007, 32'h300, 3'b000);
    MTIP = 1'b0;
    tick();

    // Drain timeout with PIPE_EMPTY held low.
    applyStimulus(1'b1, 4'd2, 32'h50, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0);
    tick();
    checkOutput("tmo_entry_derr", 32'(DRAIN_ERR), 32'd0);
    n = 0;
    while (!TRAP_REQ && n < 100) begin
      tick();
      n++;
    end
    checkOutput("tmo_cycles", 32'(n), 32'd64);
    checkOutput("tmo_derr", 32'(DRAIN_ERR), 32'd1);
    TRAP_ACK = 1'b1;
    tick();
    TRAP_ACK = 1'b0;
    tick();
    checkOutput("tmo_idle_busy", 32'(BUSY), 32'd0);
    checkOutput("tmo_sticky_derr", 32'(DRAIN_ERR), 32'd1);
    PIPE_EMPTY = 1'b1;

    // Asynchronous reset while in REQ.
    applyStimulus(1'b1, 4'd2, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    n = 0;
    while (!TRAP_REQ && n < 10) begin
      tick();
      n++;
    end
    checkOutput("mid_req", 32'(TRAP_REQ), 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(TRAP_REQ), 32'd0);
    checkOutput("mid_rst_stall", 32'(PIPE_STALL), 32'd0);
    checkOutput("mid_rst_cause", TRAP_CAUSE, 32'd0);
    checkOutput("mid_rst_derr", 32'(DRAIN_ERR), 32'd0);
    #1 RST = 1'b0;
    tick();
    checkOutput("post_rst_busy", 32'(BUSY), 32'd0);
    applyStimulus(1'b1, 4'd5, 32'h80, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
    doTrap("restart", 32'h0000_0005, 32'h80, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
